// File: rtl/start_requester_if.sv
// Handshake bundle between local job-request logic and the start requester.
// The requester itself connects through the master modport; local logic uses slave.
interface start_requester_if #(
    parameter int unsigned PEND_W = 4
);
    logic              i_req;
    logic              i_busy;
    logic              o_start;
    logic [PEND_W-1:0] o_pending;
    logic              o_done;
    logic              o_overflow;
    logic              o_timeout;

    modport master (
        input  i_req,
        input  i_busy,
        output o_start,
        output o_pending,
        output o_done,
        output o_overflow,
        output o_timeout
    );

    modport slave (
        output i_req,
        output i_busy,
        input  o_start,
        input  o_pending,
        input  o_done,
        input  o_overflow,
        input  o_timeout
    );
endinterface

// File: rtl/start_requester.sv
// Queues one-cycle job requests and issues them one at a time to a downstream busy counter.
// Optional watchdog on long busy periods is compiled in with START_REQUESTER_WATCHDOG_EN.
module start_requester #(
    parameter int unsigned PEND_W  = 4,
    parameter logic [15:0] TIMEOUT = 16'd2000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    start_requester_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    state_e            state_r;
    state_e            state_next_s;
    logic [PEND_W-1:0] pending_r;
    logic [PEND_W-1:0] pending_next_s;
    logic              accept_s;
    logic              full_s;
    logic              overflow_s;
    logic              done_s;

    assign accept_s   = (state_r == ST_REQ) && !bus.i_busy;
    assign full_s     = (pending_r == PEND_MAX);
    assign overflow_s = bus.i_req && full_s && !accept_s;
    assign done_s     = (state_r == ST_RUN) && !bus.i_busy;

    // Pending counter: a request and an acceptance in the same cycle cancel out
    always_comb begin
        pending_next_s = pending_r;
        if (bus.i_req && !accept_s) begin
            if (!full_s) begin
                pending_next_s = pending_r + PEND_ONE;
            end else begin
                pending_next_s = pending_r;
            end
        end else if (accept_s && !bus.i_req) begin
            if (pending_r != PEND_ZERO) begin
                pending_next_s = pending_r - PEND_ONE;
            end else begin
                pending_next_s = pending_r;
            end
        end else begin
            pending_next_s = pending_r;
        end
    end

    // Next-state logic for the start handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != PEND_ZERO) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_RUN: begin
                // Finishing job re-arms straight away when work is still queued
                if (!bus.i_busy) begin
                    if (pending_next_s != PEND_ZERO) begin
                        state_next_s = ST_REQ;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State and pending-count registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r   <= ST_IDLE;
            pending_r <= PEND_ZERO;
        end else begin
            state_r   <= state_next_s;
            pending_r <= pending_next_s;
        end
    end

    assign bus.o_start    = (state_r == ST_REQ);
    assign bus.o_pending  = pending_r;
    assign bus.o_done     = done_s;
    assign bus.o_overflow = overflow_s;

`ifdef START_REQUESTER_WATCHDOG_EN
    logic [15:0] wd_cnt_r;
    logic [15:0] wd_cnt_next_s;
    logic        timeout_r;
    logic        wd_hit_s;

    // Watchdog count: busy cycles in RUN, saturating at the limit
    always_comb begin
        wd_cnt_next_s = 16'd0;
        if ((state_r == ST_RUN) && bus.i_busy) begin
            if (wd_cnt_r < TIMEOUT) begin
                wd_cnt_next_s = wd_cnt_r + 16'd1;
            end else begin
                wd_cnt_next_s = wd_cnt_r;
            end
        end else begin
            wd_cnt_next_s = 16'd0;
        end
    end

    assign wd_hit_s = (state_r == ST_RUN) && bus.i_busy && (wd_cnt_next_s == TIMEOUT);

    // Watchdog registers; the error flag is sticky until reset
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wd_cnt_r  <= 16'd0;
            timeout_r <= 1'b0;
        end else begin
            wd_cnt_r  <= wd_cnt_next_s;
            timeout_r <= timeout_r | wd_hit_s;
        end
    end

    assign bus.o_timeout = timeout_r;
`else
    // TIMEOUT has no effect without the watchdog; the flag is tied low
    assign bus.o_timeout = 1'b0 & (TIMEOUT == 16'd0);
`endif

endmodule
